// File: rtl/dmem_lat_model_if.sv
// Request/response/trace bundle for dmem_lat_model.
// master = CPU/bench side, slave = memory side.
interface dmem_lat_model_if #(
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic              req_valid;
   logic              req_ready;
   logic [31:0]       req_addr;
   logic [BE_W-1:0]   req_byteen;
   logic [DATA_W-1:0] req_wdata;
   logic [31:0]       req_pc;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              trace_valid;
   logic [31:0]       trace_addr;
   logic [DATA_W-1:0] trace_wdata;
   logic [31:0]       trace_pc;

   modport master (
      output req_valid, req_addr, req_byteen, req_wdata, req_pc, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             trace_valid, trace_addr, trace_wdata, trace_pc
   );

   modport slave (
      input  req_valid, req_addr, req_byteen, req_wdata, req_pc, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             trace_valid, trace_addr, trace_wdata, trace_pc
   );
endinterface

// File: rtl/dmem_lat_model.sv
// In-order pipelined byte-enabled data memory with response FIFO and write trace.
// Optional macro DMEM_TRACE_EN prints each committed write.
module dmem_lat_model #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEPTH     = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned RSP_DEPTH = RD_LAT + 1
) (
   input logic             clk,
   input logic             reset_n,
   dmem_lat_model_if.slave bus
);
   localparam int unsigned BE_W   = DATA_W / 8;
   localparam int unsigned OFF_W  = $clog2(BE_W);
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PIPE_N = (RD_LAT > 1) ? RD_LAT - 1 : 1;
   localparam int unsigned LAST   = (RD_LAT > 1) ? RD_LAT - 2 : 0;
   localparam int unsigned PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);

   typedef struct packed {
      logic              vld;
      logic              err;
      logic [DATA_W-1:0] data;
   } rsp_t;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [31:0]       offset;
   logic [31:0]       idx;
   logic [IDX_W-1:0]  widx;
   logic              in_range;
   logic              is_write;
   logic              accept;
   logic              pop;
   logic              mem_we;
   logic [DATA_W-1:0] cur_word;
   logic [DATA_W-1:0] merged;
   rsp_t              acc_ent;
   rsp_t              push_ent;

   rsp_t              pipe_q [PIPE_N];
   rsp_t              pipe_d [PIPE_N];
   rsp_t              fifo_q [RSP_DEPTH];
   rsp_t              fifo_d [RSP_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
   logic [CNT_W-1:0]  in_flight_q, in_flight_d;
   logic              ready_en_q, ready_en_d;

   logic              trace_valid_q, trace_valid_d;
   logic [31:0]       trace_addr_q, trace_addr_d;
   logic [DATA_W-1:0] trace_wdata_q, trace_wdata_d;
   logic [31:0]       trace_pc_q, trace_pc_d;

   always_comb begin
      offset   = bus.req_addr - BASE_ADDR;
      idx      = offset >> OFF_W;
      widx     = idx[IDX_W-1:0];
      in_range = (bus.req_addr >= BASE_ADDR) && (idx < DEPTH);
      is_write = |bus.req_byteen;
      accept   = bus.req_valid && bus.req_ready;
      mem_we   = accept && is_write && in_range;
      cur_word = '0;
      if (in_range)
         cur_word = mem_q[widx];
      merged = cur_word;
      for (int unsigned i = 0; i < BE_W; i++) begin
         if (bus.req_byteen[i])
            merged[8*i +: 8] = bus.req_wdata[8*i +: 8];
      end
      acc_ent.vld  = accept;
      acc_ent.err  = !in_range;
      acc_ent.data = (!is_write && in_range) ? cur_word : '0;
   end

   // Response entries ride RD_LAT-1 stages; with RD_LAT=1 they go straight to the FIFO.
   always_comb begin
      pipe_d[0] = acc_ent;
      for (int unsigned j = 1; j < PIPE_N; j++)
         pipe_d[j] = pipe_q[j-1];
      push_ent = (RD_LAT == 1) ? acc_ent : pipe_q[LAST];
   end

   always_comb begin
      pop        = (fifo_cnt_q != '0) && bus.rsp_ready;
      fifo_d     = fifo_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      ready_en_d = 1'b1;
      if (push_ent.vld) begin
         fifo_d[wr_ptr_q] = push_ent;
         wr_ptr_d = (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop)
         rd_ptr_d = (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push_ent.vld, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
         2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
      case ({accept, pop})
         2'b10:   in_flight_d = in_flight_q + 1'b1;
         2'b01:   in_flight_d = in_flight_q - 1'b1;
         default: in_flight_d = in_flight_q;
      endcase
   end

   always_comb begin
      trace_valid_d = mem_we;
      trace_addr_d  = trace_addr_q;
      trace_wdata_d = trace_wdata_q;
      trace_pc_d    = trace_pc_q;
      if (mem_we) begin
         trace_addr_d  = bus.req_addr & ~32'(BE_W - 1);
         trace_wdata_d = merged;
         trace_pc_d    = bus.req_pc;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[widx] <= merged;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned j = 0; j < PIPE_N; j++)
            pipe_q[j] <= '0;
         for (int unsigned k = 0; k < RSP_DEPTH; k++)
            fifo_q[k] <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fifo_cnt_q    <= '0;
         in_flight_q   <= '0;
         ready_en_q    <= 1'b0;
         trace_valid_q <= 1'b0;
         trace_addr_q  <= '0;
         trace_wdata_q <= '0;
         trace_pc_q    <= '0;
      end else begin
         pipe_q        <= pipe_d;
         fifo_q        <= fifo_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fifo_cnt_q    <= fifo_cnt_d;
         in_flight_q   <= in_flight_d;
         ready_en_q    <= ready_en_d;
         trace_valid_q <= trace_valid_d;
         trace_addr_q  <= trace_addr_d;
         trace_wdata_q <= trace_wdata_d;
         trace_pc_q    <= trace_pc_d;
      end
   end

   // Pipe entries count as in flight, so the FIFO cannot overflow.
   assign bus.req_ready   = ready_en_q && (in_flight_q < CNT_W'(RSP_DEPTH));
   assign bus.rsp_valid   = (fifo_cnt_q != '0);
   assign bus.rsp_rdata   = bus.rsp_valid ? fifo_q[rd_ptr_q].data : '0;
   assign bus.rsp_err     = bus.rsp_valid ? fifo_q[rd_ptr_q].err : 1'b0;
   assign bus.trace_valid = trace_valid_q;
   assign bus.trace_addr  = trace_addr_q;
   assign bus.trace_wdata = trace_wdata_q;
   assign bus.trace_pc    = trace_pc_q;

`ifdef DMEM_TRACE_EN
   always @(posedge clk) begin
      if (reset_n && trace_valid_q)
         $display("%d@%h: *%h <= %h", $time, trace_pc_q, trace_addr_q, trace_wdata_q);
   end
`else
   // Trace ports only; no console output.
`endif
endmodule
